// File: rtl/sw_debounce_if.sv
// Switch conditioning bus: raw board levels in, debounced levels and change events out.
// The switch source is the master; the debouncer is the slave.
interface sw_debounce_if #(
    parameter int WIDTH = 24
);
    logic [WIDTH-1:0] sw_raw;
    logic [WIDTH-1:0] device_sw;
    logic [WIDTH-1:0] sw_change_mask;
    logic             sw_changed;
    logic             sample_tick;

    modport master (
        output sw_raw,
        input  device_sw,
        input  sw_change_mask,
        input  sw_changed,
        input  sample_tick
    );

    modport slave (
        input  sw_raw,
        output device_sw,
        output sw_change_mask,
        output sw_changed,
        output sample_tick
    );
endinterface

// File: rtl/sw_debounce.sv
// Board switch conditioner: two-flop synchronizer per bit, shared sample prescaler,
// per-bit saturating debounce counter and registered one-cycle change events.
module sw_debounce #(
    parameter int WIDTH      = 24,
    parameter int TICK_DIV   = 100000,
    parameter int STABLE_CNT = 4
) (
    input logic          clk,
    input logic          rst,
    sw_debounce_if.slave sw
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT + 1) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CNT - 1);

    logic [WIDTH-1:0] sync1_reg;
    logic [WIDTH-1:0] sync2_reg;
    logic [PW-1:0]    pre_cnt_reg;
    logic             sample_tick_reg;
    logic             tick_fire;
    logic [WIDTH-1:0] device_sw_reg;
    logic [WIDTH-1:0] flip_next;
    logic [WIDTH-1:0] change_mask_reg;
    logic             changed_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= sw.sw_raw;
            sync2_reg <= sync1_reg;
        end
    end

    // Debounce state advances on the same edge that raises sample_tick, so a
    // change event is always visible together with its tick.
    assign tick_fire = (pre_cnt_reg == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_cnt_reg     <= '0;
            sample_tick_reg <= 1'b0;
        end else begin
            sample_tick_reg <= tick_fire;
            if (tick_fire) begin
                pre_cnt_reg <= '0;
            end else begin
                pre_cnt_reg <= pre_cnt_reg + PW'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic [CW-1:0] cnt_reg;
            logic          level_reg;
            logic          differ;

            assign differ         = (sync2_reg[gi] != level_reg);
            assign flip_next[gi]  = tick_fire && differ && (cnt_reg == CNT_LAST);
            assign device_sw_reg[gi] = level_reg;

            // A sample matching the current level throws away partial progress.
            always_ff @(posedge clk) begin
                if (rst) begin
                    cnt_reg   <= '0;
                    level_reg <= 1'b0;
                end else if (tick_fire) begin
                    if (!differ) begin
                        cnt_reg <= '0;
                    end else if (cnt_reg == CNT_LAST) begin
                        cnt_reg   <= '0;
                        level_reg <= sync2_reg[gi];
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            change_mask_reg <= '0;
            changed_reg     <= 1'b0;
        end else begin
            change_mask_reg <= flip_next;
            changed_reg     <= |flip_next;
        end
    end

    assign sw.device_sw      = device_sw_reg;
    assign sw.sw_change_mask = change_mask_reg;
    assign sw.sw_changed     = changed_reg;
    assign sw.sample_tick    = sample_tick_reg;
endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench: dut_a (TICK_DIV=4, STABLE_CNT=3) and dut_b (TICK_DIV=1, STABLE_CNT=1)
// share clk/rst; directed stimulus queues expected change events, monitors pop on each event.
module tb_sw_debounce;
    localparam int W = 24;

    typedef struct {
        int           cyc;
        logic [W-1:0] mask;
        logic [W-1:0] dev;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rst_q = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    ev_t  q_a[$];
    ev_t  q_b[$];
    ev_t  ea;
    ev_t  eb;
    logic [W-1:0] dev_model_a = '0;
    logic [W-1:0] dev_model_b = '0;

    always #5 clk = ~clk;

    sw_debounce_if #(.WIDTH(W)) bus_a ();
    sw_debounce_if #(.WIDTH(W)) bus_b ();

    sw_debounce #(.WIDTH(W), .TICK_DIV(4), .STABLE_CNT(3)) dut_a (
        .clk(clk),
        .rst(rst),
        .sw (bus_a)
    );

    sw_debounce #(.WIDTH(W), .TICK_DIV(1), .STABLE_CNT(1)) dut_b (
        .clk(clk),
        .rst(rst),
        .sw (bus_b)
    );

    // cyc = number of clock edges since the last edge that sampled rst high
    always @(posedge clk) begin
        rst_q <= rst;
        cyc   <= rst ? 0 : cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_a(input int c, input logic [W-1:0] m, input logic [W-1:0] d);
        ev_t e;
        e.cyc = c; e.mask = m; e.dev = d;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int c, input logic [W-1:0] m, input logic [W-1:0] d);
        ev_t e;
        e.cyc = c; e.mask = m; e.dev = d;
        q_b.push_back(e);
    endtask

    task automatic wait_cyc(input int c);
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            if (cyc == c) return;
        end
        n_checks++;
        n_fail++;
        $display("FAIL wait_cyc: timed out waiting for cyc %0d (now %0d)", c, cyc);
    endtask

    task automatic drive_a(input int c, input logic [W-1:0] v);
        wait_cyc(c);
        bus_a.sw_raw = v;
        $display("drive a cyc %0d sw_raw=%h", c, v);
    endtask

    task automatic drive_b(input int c, input logic [W-1:0] v);
        wait_cyc(c);
        bus_b.sw_raw = v;
        $display("drive b cyc %0d sw_raw=%h", c, v);
    endtask

    // Monitor for dut_a
    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) begin
                check("a_rst_dev", bus_a.device_sw, 0);
                check("a_rst_mask", bus_a.sw_change_mask, 0);
                check("a_rst_flags", {bus_a.sw_changed, bus_a.sample_tick}, 0);
                dev_model_a = '0;
            end else begin
                check("a_tick", bus_a.sample_tick, (cyc % 4 == 0) && (cyc != 0));
                if (bus_a.sw_changed || bus_a.sw_change_mask != '0) begin
                    if (q_a.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL a_unexpected_event: mask %h dev %h at cyc %0d", bus_a.sw_change_mask, bus_a.device_sw, cyc);
                    end else begin
                        ea = q_a.pop_front();
                        $display("event a cyc %0d mask=%h dev=%h", cyc, bus_a.sw_change_mask, bus_a.device_sw);
                        check("a_ev_cyc", cyc, ea.cyc);
                        check("a_ev_mask", bus_a.sw_change_mask, ea.mask);
                        check("a_ev_dev", bus_a.device_sw, ea.dev);
                        check("a_ev_changed", bus_a.sw_changed, 1);
                        dev_model_a = ea.dev;
                    end
                end else begin
                    check("a_hold", bus_a.device_sw, dev_model_a);
                end
            end
        end
    end

    // Monitor for dut_b
    initial begin
        forever begin
            @(negedge clk);
            if (rst_q) begin
                check("b_rst_dev", bus_b.device_sw, 0);
                check("b_rst_mask", bus_b.sw_change_mask, 0);
                check("b_rst_flags", {bus_b.sw_changed, bus_b.sample_tick}, 0);
                dev_model_b = '0;
            end else begin
                check("b_tick", bus_b.sample_tick, 1);
                if (bus_b.sw_changed || bus_b.sw_change_mask != '0) begin
                    if (q_b.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL b_unexpected_event: mask %h dev %h at cyc %0d", bus_b.sw_change_mask, bus_b.device_sw, cyc);
                    end else begin
                        eb = q_b.pop_front();
                        $display("event b cyc %0d mask=%h dev=%h", cyc, bus_b.sw_change_mask, bus_b.device_sw);
                        check("b_ev_cyc", cyc, eb.cyc);
                        check("b_ev_mask", bus_b.sw_change_mask, eb.mask);
                        check("b_ev_dev", bus_b.device_sw, eb.dev);
                        check("b_ev_changed", bus_b.sw_changed, 1);
                        dev_model_b = eb.dev;
                    end
                end else begin
                    check("b_hold", bus_b.device_sw, dev_model_b);
                end
            end
        end
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        bus_a.sw_raw = 24'hFFFFFF;
        bus_b.sw_raw = 24'h000000;
        rst = 1'b1;
        repeat (10) @(negedge clk);
        rst = 1'b0;

        // All switches high through reset: three ticks (4, 8, 12) to flip
        push_a(12, 24'hFFFFFF, 24'hFFFFFF);
        // All fall: stable from edge 16 tick onwards, flip on tick 24
        drive_a(13, 24'h000000);
        push_a(24, 24'hFFFFFF, 24'h000000);

        // Bit 0 glitch seen by ticks 32 and 36 only, gone by 40: no event
        drive_a(26, 24'h000001);
        drive_a(35, 24'h000000);

        // Bit 5 rise (ticks 48, 52, 56) and symmetric fall (ticks 64, 68, 72)
        drive_a(42, 24'h000020);
        push_a(56, 24'h000020, 24'h000020);
        drive_a(60, 24'h000000);
        push_a(72, 24'h000000 | 24'h000020, 24'h000000);

        // Bit 0 then bit 23, one tick apart; bit 0 must start from a cleared counter
        drive_a(74, 24'h000001);
        push_a(88, 24'h000001, 24'h000001);
        drive_a(78, 24'h800001);
        push_a(92, 24'h800000, 24'h800001);

        // Bit 3 counts ticks 100 and 104, then reset wipes the progress
        drive_a(94, 24'h800009);
        wait_cyc(106);
        check("a_drained_before_rst", q_a.size(), 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        $display("rst pulse issued, sw_raw a=%h held", bus_a.sw_raw);
        push_a(12, 24'h800009, 24'h800009);

        // Fast build: 2 sync cycles + 1 update
        drive_b(20, 24'h00A5A5);
        push_b(23, 24'h00A5A5, 24'h00A5A5);
        drive_b(30, 24'h000F00);
        push_b(33, 24'h00AAA5, 24'h000F00);

        wait_cyc(40);
        check("a_queue_empty", q_a.size(), 0);
        check("b_queue_empty", q_b.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
